// File: rtl/data_mem_ctrl.sv
// Data memory for the MIPS MEM stage: byte/half/word access with sign or zero
// extension, registered read, error pulses and an optional clear-after-reset pass.
module data_mem_ctrl #(
  parameter int         RAM_SIZE_BIT   = 8,
  parameter logic [3:0] IO_NIBBLE      = 4'h4,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        ready,
  output logic        err
);

  // Handshake: ready=1 means a request with rd|wr is taken on this rising edge;
  // a taken load answers with a one-cycle rvalid after the next edge, a rejected
  // access with a one-cycle err. There is no backpressure on the response side.

  localparam int DEPTH = 1 << RAM_SIZE_BIT;

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? INIT : IDLE;

  state_t                  state;
  state_t                  state_next;
  logic [RAM_SIZE_BIT-1:0] clr_ptr;
  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    is_io;
  logic                    bad_size;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    access_err;
  logic                    access_ok;
  logic [27:0]             above_ram;
  logic [RAM_SIZE_BIT-1:0] widx;
  logic [31:0]             rword;
  logic [15:0]             lane_data;
  logic [31:0]             load_val;
  logic [31:0]             wlanes;
  logic [3:0]              wbe;
  logic                    we;

  assign ready  = (state == IDLE);
  assign accept = ready & (rd | wr);

  // Peripheral space wins over every error check; anything else outside the
  // populated words is rejected rather than aliased.
  assign above_ram    = addr[27:0] >> (RAM_SIZE_BIT + 2);
  assign is_io        = (addr[31:28] == IO_NIBBLE);
  assign bad_size     = (size == 2'b11);
  assign misaligned   = ((size == 2'b01) && addr[0]) ||
                        ((size == 2'b10) && (addr[1:0] != 2'b00));
  assign out_of_range = (above_ram != '0) || (addr[31:28] != 4'h0);
  assign access_err   = !is_io && (bad_size || misaligned || out_of_range);
  assign access_ok    = !is_io && !access_err;

  assign widx      = addr[RAM_SIZE_BIT+1:2];
  assign rword     = mem[widx];
  assign lane_data = 16'(rword >> {addr[1:0], 3'b000});
  assign we        = accept & wr & access_ok;

  always_comb begin
    load_val = rword;
    wlanes   = wdata;
    wbe      = 4'b1111;
    case (size)
      2'b00: begin
        load_val = {{24{sign & lane_data[7]}}, lane_data[7:0]};
        wlanes   = {4{wdata[7:0]}};
        wbe      = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        load_val = {{16{sign & lane_data[15]}}, lane_data[15:0]};
        wlanes   = {2{wdata[15:0]}};
        wbe      = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    if ((state == INIT) && (clr_ptr == '1)) state_next = IDLE;
  end

  // Storage has no reset so contents survive reset when clearing is disabled.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (wbe[k]) mem[widx][8*k +: 8] <= wlanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_ptr <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state  <= state_next;
      rvalid <= accept & rd;
      err    <= accept & access_err;
      if (state == INIT) clr_ptr <= clr_ptr + 1'b1;
      // Read-before-write falls out naturally: rword is the pre-edge contents.
      if (accept & rd) rdata <= access_ok ? load_val : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset/clear sequences and a
// randomized stream checked against a byte-addressed reference memory.
module tb_data_mem_ctrl;

  localparam int RSB       = 4;
  localparam int NWORDS    = 1 << RSB;
  localparam int RAM_BYTES = 4 * NWORDS;

  logic        reset;
  logic        clk;
  logic        rd;
  logic        wr;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        ready;
  logic        err;

  data_mem_ctrl #(
    .RAM_SIZE_BIT  (RSB),
    .IO_NIBBLE     (4'h4),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .reset (reset),
    .clk   (clk),
    .rd    (rd),
    .wr    (wr),
    .size  (size),
    .sign  (sign),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid),
    .ready (ready),
    .err   (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  ref_b [RAM_BYTES];
  logic [31:0] held_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_rv;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic v_rd, input logic v_wr, input logic [1:0] v_size,
                              input logic v_sign, input logic [31:0] v_addr,
                              input logic [31:0] v_wdata, input logic [31:0] v_exp,
                              input logic v_rv, input logic v_err);
    vec_t v;
    v.rd = v_rd; v.wr = v_wr; v.size = v_size; v.sign = v_sign;
    v.addr = v_addr; v.wdata = v_wdata; v.exp_rdata = v_exp;
    v.exp_rv = v_rv; v.exp_err = v_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < RAM_BYTES; i++) ref_b[i] = 8'h00;
    held_rdata = 32'h0;
  endtask

  // Reference: memory as a flat byte array, access rules from the address map.
  task automatic model_access(input logic m_rd, input logic m_wr, input logic [1:0] m_size,
                              input logic m_sign, input logic [31:0] m_addr,
                              input logic [31:0] m_wdata, output logic e_rv,
                              output logic e_err, output logic [31:0] e_rdata);
    int          nb;
    logic [31:0] v;
    logic        bad;
    e_rv  = 1'b0;
    e_err = 1'b0;
    if (m_rd | m_wr) begin
      nb = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
      if (m_addr[31:28] == 4'h4) begin
        e_rv = m_rd;
        if (m_rd) held_rdata = 32'h0;
      end else begin
        bad = (m_size == 2'd3) || ((m_addr % nb) != 0) || (m_addr >= RAM_BYTES);
        if (bad) begin
          e_err = 1'b1;
          e_rv  = m_rd;
          if (m_rd) held_rdata = 32'h0;
        end else begin
          v = 32'h0;
          for (int i = 0; i < nb; i++) v = v | (32'(ref_b[m_addr + i]) << (8 * i));
          if (m_sign && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
          if (m_rd) begin
            e_rv       = 1'b1;
            held_rdata = v;
          end
          if (m_wr) for (int i = 0; i < nb; i++) ref_b[m_addr + i] = m_wdata[8*i +: 8];
        end
      end
    end
    e_rdata = held_rdata;
  endtask

  // driver: present one request for one edge, sample #1 after the edge
  task automatic drive(input logic d_rd, input logic d_wr, input logic [1:0] d_size,
                       input logic d_sign, input logic [31:0] d_addr, input logic [31:0] d_wdata);
    rd = d_rd; wr = d_wr; size = d_size; sign = d_sign; addr = d_addr; wdata = d_wdata;
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // scoreboard step: model prediction queued, DUT response popped and compared
  logic [31:0] exp_q[$];

  task automatic run_access(input string name, input logic a_rd, input logic a_wr,
                            input logic [1:0] a_size, input logic a_sign,
                            input logic [31:0] a_addr, input logic [31:0] a_wdata);
    logic        e_rv, e_err;
    logic [31:0] e_rdata;
    model_access(a_rd, a_wr, a_size, a_sign, a_addr, a_wdata, e_rv, e_err, e_rdata);
    exp_q.push_back({30'h0, e_rv, e_err});
    exp_q.push_back(e_rdata);
    drive(a_rd, a_wr, a_size, a_sign, a_addr, a_wdata);
    check({name, " rvalid/err"}, {30'h0, rvalid, err}, exp_q.pop_front());
    check({name, " rdata"}, rdata, exp_q.pop_front());
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " init cycles"}, 32'(n), 32'(NWORDS));
  endtask

  initial begin
    logic        spurious;
    logic        d_rv, d_err;
    logic [31:0] d_rdata;
    int          n;
    int          op;
    int          s;
    int          r;
    logic [31:0] ra;

    reset = 1'b1; rd = 1'b0; wr = 1'b0; size = 2'd0; sign = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {31'h0, ready}, 32'h0);
    check("reset rvalid", {31'h0, rvalid}, 32'h0);
    check("reset err", {31'h0, err}, 32'h0);
    check("reset rdata", rdata, 32'h0);

    // requests during the clear pass must be ignored
    rd = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    spurious = 1'b0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (rvalid || err) spurious = 1'b1;
    end
    rd = 1'b0;
    wr = 1'b0;
    check("first init cycles", 32'(n), 32'(NWORDS));
    check("init ignores requests", {31'h0, spurious}, 32'h0);

    model_clear();
    for (int w = 0; w < NWORDS; w++) run_access("cleared word", 1, 0, 2'd2, 0, 32'(4 * w), 0);

    // directed vectors (RAM is 64 bytes)
    vq.push_back(mk(0, 1, 2'd2, 0, 32'h10, 32'h8081_7F01, 32'h0, 0, 0));
    vq.push_back(mk(1, 0, 2'd0, 1, 32'h10, 32'h0, 32'h0000_0001, 1, 0));
    vq.push_back(mk(1, 0, 2'd0, 1, 32'h11, 32'h0, 32'h0000_007F, 1, 0));
    vq.push_back(mk(1, 0, 2'd0, 1, 32'h12, 32'h0, 32'hFFFF_FF81, 1, 0));
    vq.push_back(mk(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 1, 0));
    vq.push_back(mk(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h0000_0080, 1, 0));
    vq.push_back(mk(1, 0, 2'd1, 0, 32'h12, 32'h0, 32'h0000_8081, 1, 0));
    vq.push_back(mk(1, 0, 2'd1, 1, 32'h12, 32'h0, 32'hFFFF_8081, 1, 0));
    vq.push_back(mk(0, 1, 2'd2, 0, 32'h20, 32'h1122_3344, 32'h0, 0, 0));
    vq.push_back(mk(0, 1, 2'd1, 0, 32'h22, 32'h0000_BEEF, 32'h0, 0, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'hBEEF_3344, 1, 0));
    vq.push_back(mk(1, 0, 2'd1, 1, 32'h22, 32'h0, 32'hFFFF_BEEF, 1, 0));
    vq.push_back(mk(1, 0, 2'd1, 0, 32'h22, 32'h0, 32'h0000_BEEF, 1, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h21, 32'h0, 32'h0, 1, 1));
    vq.push_back(mk(0, 1, 2'd1, 0, 32'h03, 32'h0000_FFFF, 32'h0, 0, 1));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h00, 32'h0, 32'h0, 1, 0));
    vq.push_back(mk(1, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h8081_7F01, 1, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h4000_0000, 32'h0, 32'h0, 1, 0));
    vq.push_back(mk(0, 1, 2'd2, 0, 32'h4000_0000, 32'hDEAD_BEEF, 32'h0, 0, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h00, 32'h0, 32'h0, 1, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 1, 1));
    vq.push_back(mk(0, 1, 2'd2, 0, 32'h40, 32'h1234_5678, 32'h0, 0, 1));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h00, 32'h0, 32'h0, 1, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h1000_0000, 32'h0, 32'h0, 1, 1));
    vq.push_back(mk(0, 1, 2'd0, 0, 32'h31, 32'h0000_00AB, 32'h0, 0, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h0000_AB00, 1, 0));
    vq.push_back(mk(0, 1, 2'd2, 0, 32'h08, 32'h1111_1111, 32'h0, 0, 0));
    vq.push_back(mk(1, 1, 2'd2, 0, 32'h08, 32'hCAFE_F00D, 32'h1111_1111, 1, 0));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h08, 32'h0, 32'hCAFE_F00D, 1, 0));
    vq.push_back(mk(1, 1, 2'd2, 0, 32'h09, 32'h0, 32'h0, 1, 1));
    vq.push_back(mk(1, 0, 2'd2, 0, 32'h08, 32'h0, 32'hCAFE_F00D, 1, 0));

    foreach (vq[i]) begin
      model_access(vq[i].rd, vq[i].wr, vq[i].size, vq[i].sign, vq[i].addr, vq[i].wdata,
                   d_rv, d_err, d_rdata);
      drive(vq[i].rd, vq[i].wr, vq[i].size, vq[i].sign, vq[i].addr, vq[i].wdata);
      check($sformatf("vec%0d rvalid", i), {31'h0, rvalid}, {31'h0, vq[i].exp_rv});
      check($sformatf("vec%0d err", i), {31'h0, err}, {31'h0, vq[i].exp_err});
      if (vq[i].exp_rv) check($sformatf("vec%0d rdata", i), rdata, vq[i].exp_rdata);
    end

    // rvalid is a single pulse and rdata holds afterwards
    drive(1, 0, 2'd2, 0, 32'h10, 0);
    model_access(1, 0, 2'd2, 0, 32'h10, 0, d_rv, d_err, d_rdata);
    check("pulse rvalid high", {31'h0, rvalid}, 32'h1);
    drive(0, 0, 2'd0, 0, 32'h0, 0);
    check("pulse rvalid low", {31'h0, rvalid}, 32'h0);
    check("rdata hold", rdata, 32'h8081_7F01);

    // randomized stream, back-to-back with occasional idles
    for (int t = 0; t < 400; t++) begin
      op = $urandom_range(0, 5);
      s  = $urandom_range(0, 9);
      r  = $urandom_range(0, 9);
      if (r == 0)      ra = {4'h4, 28'($urandom)};
      else if (r == 1) ra = 32'($urandom_range(64, 1023));
      else if (r == 2) ra = $urandom;
      else             ra = 32'($urandom_range(0, RAM_BYTES - 1));
      run_access("random", (op == 1 || op == 2 || op == 5), (op == 3 || op == 4 || op == 5),
                 (s == 9) ? 2'd3 : 2'(s % 3), 1'($urandom_range(0, 1)), ra, $urandom);
    end

    // async reset clears the response registers immediately
    run_access("pre-reset load", 1, 0, 2'd2, 0, 32'h10, 0);
    reset = 1'b1;
    #1;
    check("async reset rvalid", {31'h0, rvalid}, 32'h0);
    check("async reset rdata", rdata, 32'h0);
    check("async reset ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid-init ready", {31'h0, ready}, 32'h0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    wait_ready("restarted");
    model_clear();
    for (int w = 0; w < NWORDS; w++) run_access("recleared word", 1, 0, 2'd2, 0, 32'(4 * w), 0);

    // read-before-write on a combined access
    run_access("rbw setup", 0, 1, 2'd2, 0, 32'h08, 32'h5555_AAAA);
    run_access("rbw combined", 1, 1, 2'd2, 0, 32'h08, 32'h0BAD_F00D);
    check("rbw old data", rdata, 32'h5555_AAAA);
    run_access("rbw new data", 1, 0, 2'd2, 0, 32'h08, 0);
    check("rbw stored data", rdata, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
